seq_multiplier_32bit: RTL and testbench

//   Unsigned 32x32 -> 64-bit shift-add multiplier; sequential control stage wrapped around full_adder_32bit.

---
 rtl/seq_multiplier_32bit.sv | 147 ++++++++++++++
 tb/tb_seq_multiplier_32bit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_32bit.sv
// Unsigned shift-add multiplier controller around an external full_adder_32bit.
// Define SEQ_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier_32bit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     prod_lo_q, prod_lo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic accept;
    logic early;
    logic iterate;
    logic last_iter;

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef SEQ_MUL_EARLY_EXIT_EN
    // Remaining adds would all be +0, so the rest is just a right shift.
    assign early = (state_q == S_RUN) && (mplier_q == '0);
`else
    assign early = 1'b0;
`endif

    assign iterate   = (state_q == S_RUN) && !early && (cnt_q != '0);
    assign last_iter = iterate && (cnt_q == CW'(1));

    assign add_a = acc_hi_q;
    assign add_b = mplier_q[0] ? mcand_q : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (last_iter || early || (cnt_q == '0)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = start ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath next-state
    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_hi_d  = acc_hi_q;
        prod_lo_d = prod_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (accept) begin
            mcand_d   = A;
            mplier_d  = B;
            prod_lo_d = B;
            acc_hi_d  = '0;
            cnt_d     = CW'(WIDTH);
        end else if (iterate) begin
            // Carry-out of every add lands in the top accumulator bit.
            acc_hi_d  = {add_cout, add_sum[WIDTH-1:1]};
            prod_lo_d = {add_sum[0], prod_lo_q[WIDTH-1:1]};
            mplier_d  = mplier_q >> 1;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                product_d = {add_cout, add_sum, prod_lo_q[WIDTH-1:1]};
            end
        end
`ifdef SEQ_MUL_EARLY_EXIT_EN
        else if (early) begin
            product_d = {acc_hi_q, prod_lo_q} >> cnt_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_hi_q  <= '0;
            prod_lo_q <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_hi_q  <= acc_hi_d;
            prod_lo_q <= prod_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Bench for seq_multiplier_32bit: supplies the adder, checks products and latency against plain arithmetic.
module tb_seq_multiplier_32bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A, B;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cout;
    logic [63:0] product;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    seq_multiplier_32bit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .product  (product),
        .busy     (busy),
        .done     (done)
    );

    // Behavioural stand-in for full_adder_32bit
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Edges from accepted start until done is seen.
    function automatic int exp_lat(input logic [31:0] b);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        if (b == 32'd0) return 1;
        for (int i = 31; i >= 0; i--) begin
            if (b[i]) return (i + 2 > 32) ? 32 : i + 2;
        end
        return 32;
`else
        return 32;
`endif
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] p);
        int n;
        @(negedge clk);
        launch(a, b);
        chk({name, "_busy"}, 64'(busy), 64'd1);
        wait_done(n);
        chk({name, "_lat"}, 64'(n), 64'(exp_lat(b)));
        chk({name, "_prod"}, product, p);
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    vec_t tbl[9];

    initial begin
        int n;
        logic [31:0] ra, rb;

        tbl[0] = '{32'd3,          32'd5,          64'd15};
        tbl[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001};
        tbl[2] = '{32'h12345678,   32'd0,          64'd0};
        tbl[3] = '{32'd0,          32'hFFFFFFFF,   64'd0};
        tbl[4] = '{32'd1,          32'hFFFFFFFF,   64'h00000000_FFFFFFFF};
        tbl[5] = '{32'h80000000,   32'd2,          64'h00000001_00000000};
        tbl[6] = '{32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
        tbl[7] = '{32'h00010000,   32'h00010000,   64'h00000001_00000000};
        tbl[8] = '{32'd6,          32'd7,          64'd42};

        rst = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_product", product, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_mul($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].p);
        end

        // Product held while idle, done is a single pulse
        repeat (3) @(posedge clk);
        #1;
        chk("hold_product", product, 64'd42);
        chk("hold_done_low", 64'(done), 64'd0);

        // Async reset mid-cycle with a nonzero result held
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_product", product, 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Start during RUN ignored; start in DONE cycle accepted back-to-back
        @(negedge clk);
        launch(32'd2, 32'd9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        A = 32'd7;
        B = 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = '0;
        B = '0;
        wait_done(n);
        chk("ignore_start_lat", 64'(n + 3), 64'(exp_lat(32'd9)));
        chk("ignore_start_prod", product, 64'd18);
        launch(32'd7, 32'd7);
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(n);
        chk("b2b_lat", 64'(n), 64'(exp_lat(32'd7)));
        chk("b2b_prod", product, 64'd49);

        // Reset at iteration 10 of the worst-case operands, then a fresh multiply
        @(negedge clk);
        launch(32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_run_rst_busy", 64'(busy), 64'd0);
        chk("mid_run_rst_done", 64'(done), 64'd0);
        chk("mid_run_rst_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_mul("after_rst", 32'd6, 32'd7, 64'd42);

        // Randomized operands against plain multiplication
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_mul($sformatf("rnd%0d", i), ra, rb, {32'd0, ra} * {32'd0, rb});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
